boa_write_buffer: RTL and testbench

Posted-write buffer between boa_cache's external-memory port (xm_bus) and the memory fabric.
- Accepts cache write-backs and writes in one cycle and drains them in order to memory.
- Reads pass through with priority over draining, except when a read address hits a buffered write; the read then stalls until that write has drained.
- Provides a flush/empty handshake for fences and cache-flush sequencing.

---
 rtl/boa_write_buffer_pkg.sv | 11 +
 rtl/boa_write_buffer_if.sv | 18 +
 rtl/boa_write_buffer_fifo.sv | 86 ++++++++
 rtl/boa_write_buffer.sv | 85 ++++++++
 tb/tb_boa_write_buffer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/boa_write_buffer_pkg.sv
// Shared types for the boa write buffer: drain FSM state and the bus data width.
package boa_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } drain_state_e;

   localparam int unsigned BOA_DATA_W = 32;

endpackage

// File: rtl/boa_write_buffer_if.sv
// boa memory bus. A transfer completes in any cycle with ready=1 and (re or we!=0);
// read data follows on rdata one cycle later, and the master holds its signals while ready=0.
interface boa_mem_bus #(
   parameter int alen = 32
);
   import boa_pkg::*;

   logic                  re;
   logic [3:0]            we;
   logic [alen-1:2]       addr;
   logic [BOA_DATA_W-1:0] wdata;
   logic [BOA_DATA_W-1:0] rdata;
   logic                  ready;

   modport master (output re, we, addr, wdata, input rdata, ready);
   modport slave  (input re, we, addr, wdata, output rdata, ready);

endinterface

// File: rtl/boa_write_buffer_fifo.sv
// Circular store of posted writes with a parallel word-address hit compare over live entries.
module boa_wbuf_fifo
   import boa_pkg::*;
#(
   parameter int alen  = 32,
   parameter int depth = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [alen-1:2]         push_addr,
   input  logic [3:0]              push_we,
   input  logic [BOA_DATA_W-1:0]   push_wdata,
   input  logic                    pop,
   output logic [alen-1:2]         head_addr,
   output logic [3:0]              head_we,
   output logic [BOA_DATA_W-1:0]   head_wdata,
   output logic [$clog2(depth):0]  count,
   input  logic [alen-1:2]         hit_addr,
   output logic                    hit
);
   localparam int PW = $clog2(depth);

   typedef struct packed {
      logic [alen-1:2]       addr;
      logic [3:0]            we;
      logic [BOA_DATA_W-1:0] wdata;
   } entry_t;

   entry_t        mem_q [depth];
   entry_t        mem_d [depth];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic [PW-1:0] off;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = '{addr: push_addr, we: push_we, wdata: push_wdata};
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (PW + 1)'(1);
         2'b01:   count_d = count_q - (PW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
      mem_q <= mem_d;
   end

   // A slot is live when its distance from the head is below the occupancy.
   always_comb begin
      hit = 1'b0;
      off = '0;
      for (int i = 0; i < depth; i++) begin
         off = PW'(i) - rd_ptr_q;
         if (({1'b0, off} < count_q) && (mem_q[i].addr == hit_addr)) begin
            hit = 1'b1;
         end
      end
   end

   assign head_addr  = mem_q[rd_ptr_q].addr;
   assign head_we    = mem_q[rd_ptr_q].we;
   assign head_wdata = mem_q[rd_ptr_q].wdata;
   assign count      = count_q;

endmodule

// File: rtl/boa_write_buffer.sv
// Posted-write buffer between the cache's external port and memory: single-cycle write accept,
// in-order drain, reads forwarded ahead of the drain unless they hit a buffered word.
module boa_write_buffer
   import boa_pkg::*;
#(
   parameter int alen  = 32,
   parameter int depth = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   output logic       empty,
   boa_mem_bus.slave  s_bus,
   boa_mem_bus.master m_bus
);
   logic [$clog2(depth):0] count;
   logic [alen-1:2]        head_addr;
   logic [3:0]             head_we;
   logic [BOA_DATA_W-1:0]  head_wdata;
   logic                   hit;
   logic                   wr_req, rd_req, full;
   logic                   read_fwd, drain_present, push, pop;
   drain_state_e           state_q, state_d;

   boa_wbuf_fifo #(.alen(alen), .depth(depth)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_addr  (s_bus.addr),
      .push_we    (s_bus.we),
      .push_wdata (s_bus.wdata),
      .pop        (pop),
      .head_addr  (head_addr),
      .head_we    (head_we),
      .head_wdata (head_wdata),
      .count      (count),
      .hit_addr   (s_bus.addr),
      .hit        (hit)
   );

   always_comb begin
      wr_req   = (s_bus.we != 4'h0);
      rd_req   = s_bus.re && !wr_req;
      full     = (count == ($clog2(depth) + 1)'(depth));
      // A read may only overtake the drain while nothing is locked onto the bus.
      read_fwd      = !rst && rd_req && !hit && !flush && (state_q == IDLE);
      drain_present = !rst && !read_fwd && ((state_q == LOCK) || (count != '0));
      push          = !rst && wr_req && !full;
      pop           = drain_present && m_bus.ready;

      m_bus.re    = 1'b0;
      m_bus.we    = 4'h0;
      m_bus.addr  = '0;
      m_bus.wdata = '0;
      if (read_fwd) begin
         m_bus.re   = 1'b1;
         m_bus.addr = s_bus.addr;
      end else if (drain_present) begin
         m_bus.we    = head_we;
         m_bus.addr  = head_addr;
         m_bus.wdata = head_wdata;
      end

      s_bus.ready = wr_req ? push : (read_fwd && m_bus.ready);

      state_d = state_q;
      case (state_q)
         IDLE:    if (drain_present && !m_bus.ready) state_d = LOCK;
         LOCK:    if (m_bus.ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign s_bus.rdata = m_bus.rdata;
   assign empty       = rst || ((count == '0) && (state_q == IDLE));

endmodule

// File: tb/tb_boa_write_buffer.sv
// Directed bench for boa_write_buffer: byte addresses from the test plan are driven as word addresses.
module tb_boa_write_buffer;
   import boa_pkg::*;

   logic clk;
   logic rst;
   logic flush;
   logic empty;
   logic mem_ready;

   int tests_run;
   int tests_failed;

   logic [29:0] exp_q [$];
   logic [29:0] drain_addr_q [$];
   logic [31:0] drain_data_q [$];

   boa_mem_bus #(.alen(32)) s_if ();
   boa_mem_bus #(.alen(32)) m_if ();

   boa_write_buffer #(.alen(32), .depth(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .empty (empty),
      .s_bus (s_if.slave),
      .m_bus (m_if.master)
   );

   // Clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model
   assign m_if.ready = mem_ready;
   always @(posedge clk) begin
      m_if.rdata <= {m_if.re, 15'b0, m_if.addr[15:2], 2'b0};
   end

   // Drained-write log
   always @(posedge clk) begin
      if (!rst && mem_ready && (m_if.we != 4'h0)) begin
         drain_addr_q.push_back(m_if.addr);
         drain_data_q.push_back(m_if.wdata);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic s_idle();
      s_if.re    = 1'b0;
      s_if.we    = 4'h0;
      s_if.addr  = '0;
      s_if.wdata = '0;
   endtask

   task automatic s_write(input logic [31:0] byte_addr, input logic [3:0] we, input logic [31:0] data);
      s_if.re    = 1'b0;
      s_if.we    = we;
      s_if.addr  = byte_addr[31:2];
      s_if.wdata = data;
   endtask

   task automatic s_read(input logic [31:0] byte_addr);
      s_if.re    = 1'b1;
      s_if.we    = 4'h0;
      s_if.addr  = byte_addr[31:2];
      s_if.wdata = '0;
   endtask

   task automatic clear_logs();
      exp_q.delete();
      drain_addr_q.delete();
      drain_data_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      mem_ready = 1'b1;
      s_write(32'd2, 4'hF, 32'h1111_1111);
      @(negedge clk);
      tests_run++;
      if (s_if.ready !== 1'b0) begin tests_failed++; $display("FAIL reset_s_ready: got %b want 0", s_if.ready); end
      tests_run++;
      if (m_if.we !== 4'h0) begin tests_failed++; $display("FAIL reset_m_we: got %h want 0", m_if.we); end
      step();
      s_read(32'd8);
      @(negedge clk);
      tests_run++;
      if (m_if.re !== 1'b0) begin tests_failed++; $display("FAIL reset_m_re: got %b want 0", m_if.re); end
      tests_run++;
      if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty: got %b want 1", empty); end
      step();
      rst = 1'b0;
      s_idle();
      @(negedge clk);
      tests_run++;
      if (empty !== 1'b1) begin tests_failed++; $display("FAIL post_reset_empty: got %b want 1", empty); end
      tests_run++;
      if (m_if.we !== 4'h0) begin tests_failed++; $display("FAIL post_reset_m_we: got %h want 0", m_if.we); end
      step();
   endtask

   task automatic test_single_write();
      clear_logs();
      mem_ready = 1'b1;
      s_write(32'd2, 4'hF, 32'hDEAD_BEEF);
      @(negedge clk);
      tests_run++;
      if (s_if.ready !== 1'b1) begin tests_failed++; $display("FAIL single_ready: got %b want 1", s_if.ready); end
      tests_run++;
      if (m_if.we !== 4'h0) begin tests_failed++; $display("FAIL single_no_same_cycle: got we=%h want 0", m_if.we); end
      step();
      s_idle();
      @(negedge clk);
      tests_run++;
      if (m_if.we !== 4'hF || m_if.addr !== 30'd0 || m_if.wdata !== 32'hDEAD_BEEF) begin
         tests_failed++;
         $display("FAIL single_drain: got we=%h addr=%h data=%h want F/0/deadbeef", m_if.we, m_if.addr, m_if.wdata);
      end
      step();
      @(negedge clk);
      tests_run++;
      if (empty !== 1'b1) begin tests_failed++; $display("FAIL single_empty: got %b want 1", empty); end
      tests_run++;
      if (drain_addr_q.size() != 1) begin tests_failed++; $display("FAIL single_drain_count: got %0d want 1", drain_addr_q.size()); end
      step();
   endtask

   task automatic test_fill_full();
      int n;
      clear_logs();
      mem_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         s_write(32'(4 * i), 4'hF, 32'hF000_0000 + 32'(i));
         exp_q.push_back(30'(i));
         @(negedge clk);
         tests_run++;
         if (s_if.ready !== 1'b1) begin tests_failed++; $display("FAIL fill_ready_%0d: got %b want 1", i, s_if.ready); end
         step();
      end
      s_write(32'd20, 4'hF, 32'hF000_0005);
      @(negedge clk);
      tests_run++;
      if (s_if.ready !== 1'b0) begin tests_failed++; $display("FAIL full_ready: got %b want 0", s_if.ready); end
      tests_run++;
      if (m_if.we !== 4'hF || m_if.addr !== 30'd1) begin
         tests_failed++;
         $display("FAIL full_head: got we=%h addr=%h want F/1", m_if.we, m_if.addr);
      end
      step();
      s_idle();
      mem_ready = 1'b1;
      n = 0;
      while (!empty && n < 12) begin
         step();
         n++;
      end
      tests_run++;
      if (empty !== 1'b1) begin tests_failed++; $display("FAIL fill_drain_timeout: empty=%b after %0d cycles want 1", empty, n); end
      tests_run++;
      if (drain_addr_q.size() != 4) begin
         tests_failed++;
         $display("FAIL fill_drain_count: got %0d want 4", drain_addr_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (drain_addr_q[i] !== exp_q[i] || drain_data_q[i] !== 32'hF000_0000 + 32'(i + 1)) begin
               tests_failed++;
               $display("FAIL fill_order_%0d: got addr=%h data=%h want addr=%h", i, drain_addr_q[i], drain_data_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_read_miss();
      clear_logs();
      mem_ready = 1'b1;
      s_write(32'd40, 4'hF, 32'h0000_00AA);
      step();
      s_read(32'd34);
      @(negedge clk);
      tests_run++;
      if (m_if.re !== 1'b1 || m_if.we !== 4'h0 || m_if.addr !== 30'd8) begin
         tests_failed++;
         $display("FAIL miss_forward: got re=%b we=%h addr=%h want 1/0/8", m_if.re, m_if.we, m_if.addr);
      end
      tests_run++;
      if (s_if.ready !== 1'b1) begin tests_failed++; $display("FAIL miss_ready: got %b want 1", s_if.ready); end
      step();
      s_idle();
      @(negedge clk);
      tests_run++;
      if (s_if.rdata !== 32'h8000_0020) begin tests_failed++; $display("FAIL miss_rdata: got %h want 80000020", s_if.rdata); end
      tests_run++;
      if (m_if.we !== 4'hF || m_if.addr !== 30'd10) begin
         tests_failed++;
         $display("FAIL miss_then_drain: got we=%h addr=%h want F/a", m_if.we, m_if.addr);
      end
      step();
      @(negedge clk);
      tests_run++;
      if (empty !== 1'b1 || drain_addr_q.size() != 1) begin
         tests_failed++;
         $display("FAIL miss_drained: got empty=%b drains=%0d want 1/1", empty, drain_addr_q.size());
      end
      step();
   endtask

   task automatic test_read_hit();
      clear_logs();
      mem_ready = 1'b0;
      s_write(32'd34, 4'hF, 32'h0000_1234);
      step();
      s_read(32'd34);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         tests_run++;
         if (s_if.ready !== 1'b0 || m_if.re !== 1'b0) begin
            tests_failed++;
            $display("FAIL hit_stall_%0d: got ready=%b m_re=%b want 0/0", c, s_if.ready, m_if.re);
         end
         step();
      end
      mem_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (s_if.ready !== 1'b0 || m_if.we !== 4'hF) begin
         tests_failed++;
         $display("FAIL hit_pop_cycle: got ready=%b m_we=%h want 0/F", s_if.ready, m_if.we);
      end
      step();
      @(negedge clk);
      tests_run++;
      if (drain_addr_q.size() != 1 || drain_data_q[0] !== 32'h0000_1234) begin
         tests_failed++;
         $display("FAIL hit_write_first: got drains=%0d want 1 with data 1234", drain_addr_q.size());
      end
      tests_run++;
      if (s_if.ready !== 1'b1 || m_if.re !== 1'b1 || m_if.addr !== 30'd8) begin
         tests_failed++;
         $display("FAIL hit_read_done: got ready=%b re=%b addr=%h want 1/1/8", s_if.ready, m_if.re, m_if.addr);
      end
      step();
      s_idle();
      @(negedge clk);
      tests_run++;
      if (s_if.rdata !== 32'h8000_0020) begin tests_failed++; $display("FAIL hit_rdata: got %h want 80000020", s_if.rdata); end
      step();
   endtask

   task automatic test_lock_stability();
      clear_logs();
      mem_ready = 1'b0;
      s_write(32'd80, 4'h3, 32'hA5A5_0001);
      step();
      s_idle();
      for (int c = 0; c < 3; c++) begin
         if (c == 2) mem_ready = 1'b1;
         @(negedge clk);
         tests_run++;
         if (m_if.we !== 4'h3 || m_if.addr !== 30'd20 || m_if.wdata !== 32'hA5A5_0001 || m_if.re !== 1'b0) begin
            tests_failed++;
            $display("FAIL lock_hold_%0d: got re=%b we=%h addr=%h data=%h want 0/3/14/a5a50001",
                     c, m_if.re, m_if.we, m_if.addr, m_if.wdata);
         end
         if (c > 0) begin
            tests_run++;
            if (s_if.ready !== 1'b0) begin tests_failed++; $display("FAIL lock_read_held_%0d: got %b want 0", c, s_if.ready); end
         end
         step();
         s_read(32'd120);
      end
      @(negedge clk);
      tests_run++;
      if (s_if.ready !== 1'b1 || m_if.re !== 1'b1) begin
         tests_failed++;
         $display("FAIL lock_read_after: got ready=%b re=%b want 1/1", s_if.ready, m_if.re);
      end
      step();
      s_idle();
      @(negedge clk);
      tests_run++;
      if (s_if.rdata !== 32'h8000_0078) begin tests_failed++; $display("FAIL lock_rdata: got %h want 80000078", s_if.rdata); end
      step();
   endtask

   task automatic test_flush_reset();
      int n;
      logic saw_write;
      clear_logs();
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_write(32'(160 + 4 * i), 4'hF, 32'hC000_0000 + 32'(i));
         exp_q.push_back(30'(40 + i));
         step();
      end
      flush = 1'b1;
      s_read(32'd200);
      mem_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (s_if.ready !== 1'b0 || empty !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_read_held: got ready=%b empty=%b want 0/0", s_if.ready, empty);
      end
      s_idle();
      n = 0;
      while (!empty && n < 12) begin
         step();
         n++;
      end
      tests_run++;
      if (empty !== 1'b1 || n != 3) begin
         tests_failed++;
         $display("FAIL flush_empty: got empty=%b after %0d cycles want 1 after 3", empty, n);
      end
      tests_run++;
      if (drain_addr_q.size() != 3 || drain_addr_q[0] !== exp_q[0] || drain_addr_q[2] !== exp_q[2]) begin
         tests_failed++;
         $display("FAIL flush_order: got %0d drains want 3 in order 28..2a", drain_addr_q.size());
      end
      flush = 1'b0;
      clear_logs();
      mem_ready = 1'b0;
      s_write(32'd240, 4'hF, 32'h0000_0060);
      step();
      s_write(32'd244, 4'hF, 32'h0000_0061);
      step();
      s_idle();
      rst = 1'b1;
      @(negedge clk);
      tests_run++;
      if (empty !== 1'b1 || m_if.we !== 4'h0 || m_if.re !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_mid_drain: got empty=%b we=%h re=%b want 1/0/0", empty, m_if.we, m_if.re);
      end
      step();
      rst = 1'b0;
      mem_ready = 1'b1;
      saw_write = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (m_if.we !== 4'h0) saw_write = 1'b1;
         step();
      end
      tests_run++;
      if (saw_write !== 1'b0 || drain_addr_q.size() != 0) begin
         tests_failed++;
         $display("FAIL rst_discard: got stray_we=%b drains=%0d want 0/0", saw_write, drain_addr_q.size());
      end
      tests_run++;
      if (empty !== 1'b1) begin tests_failed++; $display("FAIL rst_final_empty: got %b want 1", empty); end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      flush        = 1'b0;
      mem_ready    = 1'b1;
      s_idle();
      step();
      test_reset();
      test_single_write();
      test_fill_full();
      test_read_miss();
      test_read_hit();
      test_lock_stability();
      test_flush_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
